// File: rtl/axi_lite_wr_rd_checker.sv
// AXI4-Lite write/readback checker.
// On start, writes a generated pattern to NUM_VECTORS addresses and reads it
// back, either interleaved per vector (MODE 0) or as a full write pass followed
// by a full read pass (MODE 1). Every handshake wait is bounded by TIMEOUT_CYCLES.
// Ports:
//   ACLK, ARESET           clock, synchronous active-high reset
//   start / busy / done    run request, run in progress, one-cycle completion pulse
//   pass, err_count,       result status, held until the next accepted start
//   timeout, first_err_idx
//   m_axi_*                AXI4-Lite master (AW, W, B, AR, R channels)
module axi_lite_wr_rd_checker #(
  parameter int unsigned                          C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                          C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                          NUM_VECTORS        = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0]        BASE_ADDR          = '0,
  parameter int unsigned                          ADDR_STRIDE        = 4,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0]        DATA_SEED          = 'h0101FFFF,
  parameter logic [C_M_AXI_DATA_WIDTH-1:0]        DATA_STEP          = 'h11110001,
  parameter int unsigned                          MODE               = 0,
  parameter int unsigned                          TIMEOUT_CYCLES     = 1024
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [7:0]                        err_count,
  output logic                              timeout,
  output logic [7:0]                        first_err_idx,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                        m_axi_awprot,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                        m_axi_arprot,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, NEXT, FINISH
  } state_t;

  state_t                          state, state_nxt;
  logic [7:0]                      idx;
  logic                            rd_pass;
  logic                            aw_done, w_done;
  logic [31:0]                     wait_cnt;
  logic                            err_seen;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   vec_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   vec_data;
  logic                            aw_hs, w_hs, wr_both;
  logic                            b_hs, r_hs;
  logic                            wait_hit, last_vec, log_err, to_fire;

  always_comb begin
    vec_addr = BASE_ADDR + C_M_AXI_ADDR_WIDTH'(idx) * C_M_AXI_ADDR_WIDTH'(ADDR_STRIDE);
    vec_data = DATA_SEED + C_M_AXI_DATA_WIDTH'(idx) * DATA_STEP;
  end

  // Handshakes are derived from state rather than the valid outputs so the
  // output decode below does not feed back into itself.
  always_comb begin
    aw_hs    = (state == WR) && !aw_done && m_axi_awready;
    w_hs     = (state == WR) && !w_done  && m_axi_wready;
    wr_both  = (aw_done || aw_hs) && (w_done || w_hs);
    b_hs     = (state == WR_RESP) && m_axi_bvalid;
    r_hs     = (state == RD_DATA) && m_axi_rvalid;
    wait_hit = (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
    last_vec = (idx == 8'(NUM_VECTORS - 1));
    log_err  = (b_hs && (m_axi_bresp != 2'b00)) ||
               (r_hs && ((m_axi_rresp != 2'b00) || (m_axi_rdata != vec_data)));
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    to_fire       = 1'b0;
    busy          = (state != IDLE);
    done          = 1'b0;
    m_axi_awaddr  = '0;
    m_axi_awprot  = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_araddr  = '0;
    m_axi_arprot  = '0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = WR;
      end
      WR: begin
        m_axi_awvalid = !aw_done;
        m_axi_wvalid  = !w_done;
        if (!aw_done) m_axi_awaddr = vec_addr;
        if (!w_done) begin
          m_axi_wdata = vec_data;
          m_axi_wstrb = '1;
        end
        // A handshake landing on the last wait cycle still wins over timeout.
        if (wr_both)       state_nxt = WR_RESP;
        else if (wait_hit) begin
          to_fire   = 1'b1;
          state_nxt = FINISH;
        end
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid)  state_nxt = (MODE == 0) ? RD_ADDR : NEXT;
        else if (wait_hit) begin
          to_fire   = 1'b1;
          state_nxt = FINISH;
        end
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        m_axi_araddr  = vec_addr;
        if (m_axi_arready) state_nxt = RD_DATA;
        else if (wait_hit) begin
          to_fire   = 1'b1;
          state_nxt = FINISH;
        end
      end
      RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid)  state_nxt = NEXT;
        else if (wait_hit) begin
          to_fire   = 1'b1;
          state_nxt = FINISH;
        end
      end
      NEXT: begin
        if (last_vec)
          state_nxt = ((MODE != 0) && !rd_pass) ? RD_ADDR : FINISH;
        else
          state_nxt = ((MODE != 0) && rd_pass) ? RD_ADDR : WR;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      idx           <= '0;
      rd_pass       <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      wait_cnt      <= '0;
      err_count     <= '0;
      err_seen      <= 1'b0;
      first_err_idx <= '0;
      timeout       <= 1'b0;
      pass          <= 1'b0;
    end else begin
      if ((state == IDLE) || (state_nxt != state)) wait_cnt <= '0;
      else                                         wait_cnt <= wait_cnt + 32'd1;

      if (state == WR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end

      if ((state == IDLE) && start) begin
        idx           <= '0;
        rd_pass       <= 1'b0;
        err_count     <= '0;
        err_seen      <= 1'b0;
        first_err_idx <= '0;
        timeout       <= 1'b0;
        pass          <= 1'b0;
      end

      if (log_err) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (!err_seen) begin
          err_seen      <= 1'b1;
          first_err_idx <= idx;
        end
      end

      if (to_fire) timeout <= 1'b1;

      if (state == NEXT) begin
        if (!last_vec)                     idx <= idx + 8'd1;
        else if ((MODE != 0) && !rd_pass) begin
          idx     <= '0;
          rd_pass <= 1'b1;
        end
      end

      // Pass is latched on entry to FINISH so it is valid alongside done.
      if ((state_nxt == FINISH) && (state != FINISH))
        pass <= !to_fire && !timeout && (err_count == 8'd0);
    end
  end

endmodule

// File: tb/tb_axi_lite_wr_rd_checker.sv
// Directed bench: three checker instances (MODE 0, MODE 1, MODE 0 with a short
// timeout) share one AXI4-Lite memory slave model selected by sel.
`timescale 1ns/1ps
module tb_axi_lite_wr_rd_checker;
  localparam int NDUT = 3;

  logic tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  logic        ARESET;
  logic        start_v   [NDUT];
  logic        busy_v    [NDUT];
  logic        done_v    [NDUT];
  logic        pass_v    [NDUT];
  logic        timeout_v [NDUT];
  logic [7:0]  err_v     [NDUT];
  logic [7:0]  fidx_v    [NDUT];
  logic [31:0] awaddr_v  [NDUT];
  logic [2:0]  awprot_v  [NDUT];
  logic        awvalid_v [NDUT];
  logic        awready_v [NDUT];
  logic [31:0] wdata_v   [NDUT];
  logic [3:0]  wstrb_v   [NDUT];
  logic        wvalid_v  [NDUT];
  logic        wready_v  [NDUT];
  logic [1:0]  bresp_v   [NDUT];
  logic        bvalid_v  [NDUT];
  logic        bready_v  [NDUT];
  logic [31:0] araddr_v  [NDUT];
  logic [2:0]  arprot_v  [NDUT];
  logic        arvalid_v [NDUT];
  logic        arready_v [NDUT];
  logic [31:0] rdata_v   [NDUT];
  logic [1:0]  rresp_v   [NDUT];
  logic        rvalid_v  [NDUT];
  logic        rready_v  [NDUT];

  // slave-side registers
  int          sel;
  logic        sl_awready, sl_wready, sl_bvalid, sl_arready, sl_rvalid;
  logic [1:0]  sl_bresp, sl_rresp;
  logic [31:0] sl_rdata;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    axi_lite_wr_rd_checker #(
      .MODE           (g == 1 ? 1 : 0),
      .TIMEOUT_CYCLES (g == 2 ? 16 : 1024)
    ) u_dut (
      .ACLK          (tb_ACLK),
      .ARESET        (ARESET),
      .start         (start_v[g]),
      .busy          (busy_v[g]),
      .done          (done_v[g]),
      .pass          (pass_v[g]),
      .err_count     (err_v[g]),
      .timeout       (timeout_v[g]),
      .first_err_idx (fidx_v[g]),
      .m_axi_awaddr  (awaddr_v[g]),
      .m_axi_awprot  (awprot_v[g]),
      .m_axi_awvalid (awvalid_v[g]),
      .m_axi_awready (awready_v[g]),
      .m_axi_wdata   (wdata_v[g]),
      .m_axi_wstrb   (wstrb_v[g]),
      .m_axi_wvalid  (wvalid_v[g]),
      .m_axi_wready  (wready_v[g]),
      .m_axi_bresp   (bresp_v[g]),
      .m_axi_bvalid  (bvalid_v[g]),
      .m_axi_bready  (bready_v[g]),
      .m_axi_araddr  (araddr_v[g]),
      .m_axi_arprot  (arprot_v[g]),
      .m_axi_arvalid (arvalid_v[g]),
      .m_axi_arready (arready_v[g]),
      .m_axi_rdata   (rdata_v[g]),
      .m_axi_rresp   (rresp_v[g]),
      .m_axi_rvalid  (rvalid_v[g]),
      .m_axi_rready  (rready_v[g])
    );
    assign awready_v[g] = (sel == g) ? sl_awready : 1'b0;
    assign wready_v[g]  = (sel == g) ? sl_wready  : 1'b0;
    assign bvalid_v[g]  = (sel == g) ? sl_bvalid  : 1'b0;
    assign bresp_v[g]   = (sel == g) ? sl_bresp   : 2'b00;
    assign arready_v[g] = (sel == g) ? sl_arready : 1'b0;
    assign rvalid_v[g]  = (sel == g) ? sl_rvalid  : 1'b0;
    assign rdata_v[g]   = (sel == g) ? sl_rdata   : 32'h0;
    assign rresp_v[g]   = (sel == g) ? sl_rresp   : 2'b00;
  end

  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_awprot, s_arprot;
  always_comb begin
    s_awvalid = awvalid_v[sel];
    s_awaddr  = awaddr_v[sel];
    s_awprot  = awprot_v[sel];
    s_wvalid  = wvalid_v[sel];
    s_wdata   = wdata_v[sel];
    s_wstrb   = wstrb_v[sel];
    s_bready  = bready_v[sel];
    s_arvalid = arvalid_v[sel];
    s_araddr  = araddr_v[sel];
    s_arprot  = arprot_v[sel];
    s_rready  = rready_v[sel];
  end

  // slave behaviour knobs
  bit aw_after_w, rand_delay, never_b, ar_stall, corrupt_en, berr_en;

  logic [31:0] mem [16];
  bit          tx_rd   [$];
  logic [31:0] tx_addr [$];
  logic [31:0] tx_data [$];

  int   cyc, proto_err, w_hs_cyc;
  int   done_cnt [NDUT];
  bit   aw_got, w_got, b_busy, ar_got, b_fire, r_fire;
  int   w_gap, b_cnt, r_cnt;
  logic [31:0] aw_a, w_d, ar_a;
  logic [1:0]  bresp_nx;
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rst;
  logic [31:0] p_awa, p_wd, p_ara;

  always @(posedge tb_ACLK) cyc++;

  always @(negedge tb_ACLK)
    for (int k = 0; k < NDUT; k++) if (done_v[k]) done_cnt[k]++;

  // Slave decisions are made on the falling edge: a ready raised here against
  // a valid already high completes on the following rising edge.
  always @(negedge tb_ACLK) begin
    if (ARESET) begin
      sl_awready = 0; sl_wready = 0; sl_bvalid = 0; sl_bresp = 0;
      sl_arready = 0; sl_rvalid = 0; sl_rdata = 0; sl_rresp = 0;
      aw_got = 0; w_got = 0; b_busy = 0; ar_got = 0; b_fire = 0; r_fire = 0; w_gap = 0;
    end else begin
      if (p_awv && !p_awr && !p_rst && (!s_awvalid || s_awaddr !== p_awa)) proto_err++;
      if (p_wv  && !p_wr  && !p_rst && (!s_wvalid  || s_wdata  !== p_wd))  proto_err++;
      if (p_arv && !p_arr && !p_rst && (!s_arvalid || s_araddr !== p_ara)) proto_err++;
      if (s_wvalid && s_wstrb !== 4'hF) proto_err++;
      if ((s_awvalid && s_awprot !== 3'd0) || (s_arvalid && s_arprot !== 3'd0)) proto_err++;

      if (b_fire) begin sl_bvalid = 0; aw_got = 0; w_got = 0; b_busy = 0; end
      if (r_fire) begin sl_rvalid = 0; ar_got = 0; end
      if (w_got && w_gap < 255) w_gap++;

      if (aw_got && w_got && !b_busy) begin
        mem[aw_a[5:2]] = w_d;
        tx_rd.push_back(1'b0); tx_addr.push_back(aw_a); tx_data.push_back(w_d);
        b_busy   = 1;
        b_cnt    = rand_delay ? int'($urandom_range(4, 0)) : 0;
        bresp_nx = (berr_en && aw_a == 32'hC) ? 2'b10 : 2'b00;
      end
      if (b_busy && !sl_bvalid && !never_b) begin
        if (b_cnt == 0) begin sl_bvalid = 1; sl_bresp = bresp_nx; end
        else b_cnt--;
      end

      if (ar_got && !sl_rvalid) begin
        if (r_cnt == 0) begin
          sl_rvalid = 1;
          sl_rresp  = 2'b00;
          sl_rdata  = (corrupt_en && ar_a == 32'h8) ? 32'hDEAD0011 : mem[ar_a[5:2]];
          tx_rd.push_back(1'b1); tx_addr.push_back(ar_a); tx_data.push_back(sl_rdata);
        end else r_cnt--;
      end

      if (w_got) sl_wready = 0;
      else if (s_wvalid) begin
        sl_wready = 1; w_got = 1; w_d = s_wdata; w_gap = 0; w_hs_cyc = cyc + 1;
      end else sl_wready = 0;

      if (aw_got) sl_awready = 0;
      else if (s_awvalid && (!aw_after_w || (w_got && w_gap >= 3))) begin
        sl_awready = 1; aw_got = 1; aw_a = s_awaddr;
      end else sl_awready = 0;

      if (ar_got || ar_stall) sl_arready = 0;
      else if (s_arvalid) begin
        sl_arready = 1; ar_got = 1; ar_a = s_araddr;
        r_cnt = rand_delay ? int'($urandom_range(4, 0)) : 0;
      end else sl_arready = 0;

      b_fire = sl_bvalid && s_bready;
      r_fire = sl_rvalid && s_rready;
    end
    p_awv = s_awvalid; p_awr = sl_awready; p_awa = s_awaddr;
    p_wv  = s_wvalid;  p_wr  = sl_wready;  p_wd  = s_wdata;
    p_arv = s_arvalid; p_arr = sl_arready; p_ara = s_araddr;
    p_rst = ARESET;
  end

  int n_cmp, n_bad;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic do_reset();
    ARESET = 1'b1; tick(); tick();
    ARESET = 1'b0; tick();
  endtask

  task automatic pulse_start(input int k);
    start_v[k] = 1'b1; tick(); start_v[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (done_v[k]) begin at = cyc; break; end
      tick();
    end
    check_val($sformatf("done_seen_dut%0d", k), 64'(at >= 0), 64'd1);
  endtask

  function automatic logic [63:0] outs(input int k);
    return 64'({busy_v[k], done_v[k], pass_v[k], timeout_v[k], err_v[k], fidx_v[k],
                awvalid_v[k], wvalid_v[k], bready_v[k], arvalid_v[k], rready_v[k], araddr_v[k]});
  endfunction

  logic [31:0] exp_data [4] = '{32'h0101FFFF, 32'h12130000, 32'h23240001, 32'h34350002};

  task automatic check_log(input string tag, input bit mode1);
    check_val({tag, "_len"}, 64'(tx_rd.size()), 64'd8);
    for (int i = 0; i < 8 && i < tx_rd.size(); i++) begin
      int v;
      bit rd;
      v  = mode1 ? i % 4 : i / 2;
      rd = mode1 ? (i >= 4) : (i % 2 == 1);
      check_val($sformatf("%s_kind%0d", tag, i), 64'(tx_rd[i]), 64'(rd));
      check_val($sformatf("%s_addr%0d", tag, i), 64'(tx_addr[i]), 64'(v * 4));
      check_val($sformatf("%s_data%0d", tag, i), 64'(tx_data[i]), 64'(exp_data[v]));
    end
  endtask

  task automatic clear_log();
    tx_rd.delete(); tx_addr.delete(); tx_data.delete();
  endtask

  initial begin
    #300000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int at, seen, d0;
    ARESET = 1'b1;
    sel = 0;
    for (int k = 0; k < NDUT; k++) start_v[k] = 1'b0;
    tick(); tick(); tick();
    ARESET = 1'b0;
    tick();
    for (int k = 0; k < NDUT; k++) check_val($sformatf("reset_outs_dut%0d", k), outs(k), 64'd0);

    // interleaved write/readback, zero-wait slave
    sel = 0; clear_log();
    pulse_start(0); wait_done(0, 300, at);
    check_val("m0_pass", 64'(pass_v[0]), 64'd1);
    check_val("m0_err", 64'(err_v[0]), 64'd0);
    check_val("m0_timeout", 64'(timeout_v[0]), 64'd0);
    check_log("m0_log", 1'b0);
    tick();
    check_val("m0_pass_hold", 64'(pass_v[0]), 64'd1);
    check_val("m0_idle", 64'(busy_v[0]), 64'd0);

    // write pass then read pass
    do_reset(); sel = 1; clear_log();
    pulse_start(1); wait_done(1, 300, at);
    check_val("m1_pass", 64'(pass_v[1]), 64'd1);
    check_val("m1_err", 64'(err_v[1]), 64'd0);
    check_log("m1_log", 1'b1);

    // awready trails wready by 3 cycles, random B/R latency
    do_reset(); sel = 0; clear_log();
    aw_after_w = 1; rand_delay = 1; proto_err = 0;
    pulse_start(0); wait_done(0, 600, at);
    check_val("slow_pass", 64'(pass_v[0]), 64'd1);
    check_val("slow_proto", 64'(proto_err), 64'd0);
    check_log("slow_log", 1'b0);
    aw_after_w = 0; rand_delay = 0;

    // B never returned, 16-cycle timeout
    do_reset(); sel = 2; never_b = 1;
    pulse_start(2); wait_done(2, 200, at);
    check_val("to_timeout", 64'(timeout_v[2]), 64'd1);
    check_val("to_pass", 64'(pass_v[2]), 64'd0);
    check_val("to_latency_ok", 64'((at - w_hs_cyc) >= 16 && (at - w_hs_cyc) <= 17), 64'd1);
    check_val("to_bready_dropped", 64'(bready_v[2]), 64'd0);
    tick();
    check_val("to_idle", 64'(busy_v[2]), 64'd0);
    check_val("to_timeout_hold", 64'(timeout_v[2]), 64'd1);

    // read corruption on vector 2, SLVERR on vector 3 write
    do_reset(); never_b = 0; sel = 0; corrupt_en = 1; berr_en = 1;
    pulse_start(0); wait_done(0, 300, at);
    check_val("err_count", 64'(err_v[0]), 64'd2);
    check_val("err_first_idx", 64'(fidx_v[0]), 64'd2);
    check_val("err_pass", 64'(pass_v[0]), 64'd0);
    check_val("err_timeout", 64'(timeout_v[0]), 64'd0);
    tick(); tick(); tick();
    check_val("err_count_hold", 64'(err_v[0]), 64'd2);
    corrupt_en = 0; berr_en = 0;
    ARESET = 1'b1; tick();
    check_val("rst_clears_status", outs(0), 64'd0);
    ARESET = 1'b0; tick();

    // reset while arvalid is pending
    ar_stall = 1;
    pulse_start(0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (arvalid_v[0]) begin seen = 1; break; end
      tick();
    end
    check_val("arvalid_pending", 64'(seen), 64'd1);
    ARESET = 1'b1; tick();
    check_val("rst_mid_ar_outs", outs(0), 64'd0);
    check_val("rst_mid_ar_arvalid", 64'(arvalid_v[0]), 64'd0);
    ARESET = 1'b0; ar_stall = 0; tick();

    // clean rerun with a stray start while busy
    clear_log(); d0 = done_cnt[0];
    pulse_start(0); tick(); tick();
    check_val("rerun_busy", 64'(busy_v[0]), 64'd1);
    pulse_start(0);
    wait_done(0, 300, at);
    check_val("rerun_pass", 64'(pass_v[0]), 64'd1);
    for (int i = 0; i < 30; i++) tick();
    check_val("rerun_single_done", 64'(done_cnt[0] - d0), 64'd1);
    check_val("rerun_idle", 64'(busy_v[0]), 64'd0);
    check_log("rerun_log", 1'b0);
    check_val("proto_total", 64'(proto_err), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
